// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: pointer geometry and gray-code helper,
// used by both the read-side stream stage and the write-side full logic.
package async_fifo_pkg;

  localparam int ADDRSIZE = 4;
  localparam int PTRW     = ADDRSIZE + 1;
  localparam int DEPTH    = 2 ** ADDRSIZE;

  // Works for any pointer width up to 32 bits when the caller zero-extends.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: pops into a 2-entry head/skid buffer
// exposed as valid/ready, and reports a registered fill level from gray pointers.
module fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  input  logic [DSIZE-1:0]    rdata,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic                rinc,
  output logic                m_valid,
  output logic [DSIZE-1:0]    m_data,
  input  logic                m_ready,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                ralmost_empty
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [1:0]       cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic [PW-1:0]    lvl_q, lvl_d;
  logic             ae_q, ae_d;
  logic             push, pop;

  // Pop request depends only on registered state, never on m_ready.
  assign rinc    = ~rempty & (cnt_q != 2'd2);
  assign push    = rinc;
  assign pop     = vld_q & m_ready;
  assign m_valid = vld_q;
  assign m_data  = head_q;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = rdata;
          cnt_d  = 2'd1;
        end else begin
          skid_d = rdata;
          cnt_d  = 2'd2;
        end
      end
      2'b01: begin
        if (cnt_q == 2'd2) begin
          head_d = skid_q;
          cnt_d  = 2'd1;
        end else begin
          cnt_d  = 2'd0;
        end
      end
      // Only reachable at cnt 1: head is replaced in place.
      2'b11: head_d = rdata;
      default: ;
    endcase
    vld_d = (cnt_d != 2'd0);
  end

  // Modulo subtraction of the binary pointers handles wrap and full (= DEPTH).
  always_comb begin
    lvl_d = PW'(gray2bin(32'(rq2_wptr)) - gray2bin(32'(rptr)));
    ae_d  = (lvl_d <= AE_T);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q  <= 2'd0;
      vld_q  <= 1'b0;
      head_q <= '0;
      skid_q <= '0;
      lvl_q  <= '0;
      ae_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      head_q <= head_d;
      skid_q <= skid_d;
      lvl_q  <= lvl_d;
      ae_q   <= ae_d;
    end
  end

  assign rlevel        = lvl_q;
  assign ralmost_empty = ae_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: FIFO memory/pointer model plus
// a level table and hand sequences for streaming corner cases.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic [4:0] rptr, rq2_wptr;
  logic       rinc, m_valid, m_ready, ralmost_empty;
  logic [7:0] m_data;
  logic [4:0] rlevel;

  logic [7:0] mem [16];
  logic [4:0] rb, wb;
  logic       ovr;
  logic [4:0] ov_r, ov_w;

  int errs = 0;
  int checks = 0;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DSIZE(8), .ADDRSIZE(4), .AE_THRESH(2)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
    .rptr(rptr), .rq2_wptr(rq2_wptr), .rinc(rinc), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .rlevel(rlevel),
    .ralmost_empty(ralmost_empty)
  );

  function automatic logic [4:0] bin2gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Read-pointer model: advances on every pop request.
  always @(posedge rclk or negedge rrst_n)
    if (!rrst_n) rb <= 5'd0;
    else if (rinc) rb <= rb + 5'd1;

  assign rempty   = ovr | (rb == wb);
  assign rdata    = mem[rb[3:0]];
  assign rptr     = ovr ? bin2gray(ov_r) : bin2gray(rb);
  assign rq2_wptr = ovr ? bin2gray(ov_w) : bin2gray(wb);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] r;
    logic [4:0] w;
    logic [4:0] lvl;
    logic       ae;
  } lv_t;
  lv_t tbl [8];

  initial begin
    tbl[0] = '{r: 5'd30, w: 5'd3,  lvl: 5'd5,  ae: 1'b0};
    tbl[1] = '{r: 5'd7,  w: 5'd7,  lvl: 5'd0,  ae: 1'b1};
    tbl[2] = '{r: 5'd0,  w: 5'd16, lvl: 5'd16, ae: 1'b0};
    tbl[3] = '{r: 5'd5,  w: 5'd7,  lvl: 5'd2,  ae: 1'b1};
    tbl[4] = '{r: 5'd5,  w: 5'd8,  lvl: 5'd3,  ae: 1'b0};
    tbl[5] = '{r: 5'd31, w: 5'd1,  lvl: 5'd2,  ae: 1'b1};
    tbl[6] = '{r: 5'd20, w: 5'd4,  lvl: 5'd16, ae: 1'b0};
    tbl[7] = '{r: 5'd0,  w: 5'd1,  lvl: 5'd1,  ae: 1'b1};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    ovr = 1'b0; ov_r = '0; ov_w = '0;
    wb = 5'd0; m_ready = 1'b0; rrst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge rclk);
    chk("rst m_valid", m_valid, 0);
    chk("rst rinc", rinc, 0);
    chk("rst m_data", m_data, 0);
    chk("rst rlevel", rlevel, 0);
    chk("rst ae", ralmost_empty, 1);
    rrst_n = 1'b1;
    @(negedge rclk);

    // Steady throughput: six words, one per cycle
    for (int i = 0; i < 6; i++) mem[i] = 8'h11 + 8'(i);
    m_ready = 1'b1;
    wb = 5'd6;
    for (int i = 0; i < 6; i++) begin
      @(negedge rclk);
      chk("thru valid", m_valid, 1);
      chk("thru data", m_data, 8'h11 + i);
    end
    @(negedge rclk);
    chk("thru drain valid", m_valid, 0);
    chk("thru drain level", rlevel, 0);

    // Backpressure: exactly two pops fill the buffer, head held
    mem[6] = 8'h11; mem[7] = 8'h12; mem[8] = 8'h13;
    m_ready = 1'b0;
    wb = 5'd9;
    begin
      int pulses = 0;
      #1;
      for (int i = 0; i < 6; i++) begin
        pulses += int'(rinc);
        @(negedge rclk);
        chk("bp valid", m_valid, 1);
        chk("bp head", m_data, 8'h11);
      end
      chk("bp rinc pulses", pulses, 2);
      chk("bp rinc idle", rinc, 0);
      chk("bp level", rlevel, 1);
    end
    m_ready = 1'b1;
    #1;
    chk("bp out0", m_data, 8'h11);
    for (int i = 1; i < 3; i++) begin
      @(negedge rclk);
      chk("bp valid out", m_valid, 1);
      chk("bp order", m_data, 8'h11 + i);
    end
    @(negedge rclk);
    chk("bp end valid", m_valid, 0);

    // Single word latency
    mem[9] = 8'h5A;
    wb = 5'd10;
    #1;
    chk("single rinc", rinc, 1);
    chk("single pre valid", m_valid, 0);
    @(negedge rclk);
    chk("single valid", m_valid, 1);
    chk("single data", m_data, 8'h5A);
    chk("single rinc empty", rinc, 0);
    @(negedge rclk);
    chk("single drop", m_valid, 0);
    chk("single rinc stay", rinc, 0);

    // Reset mid-stream with a full buffer
    mem[10] = 8'hA0; mem[11] = 8'hA1; mem[12] = 8'hA2;
    m_ready = 1'b0;
    wb = 5'd13;
    repeat (3) @(negedge rclk);
    chk("pre-rst valid", m_valid, 1);
    chk("pre-rst rinc", rinc, 0);
    chk("pre-rst ae", ralmost_empty, 1);
    wb = 5'd0;
    rrst_n = 1'b0;
    #1;
    chk("midrst valid", m_valid, 0);
    chk("midrst rinc", rinc, 0);
    chk("midrst ae", ralmost_empty, 1);
    chk("midrst data", m_data, 0);
    @(negedge rclk);
    rrst_n = 1'b1;
    @(negedge rclk);
    chk("post-rst valid", m_valid, 0);

    // Level table, pointers driven directly
    ovr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ov_r = tbl[i].r;
      ov_w = tbl[i].w;
      @(negedge rclk);
      chk($sformatf("level[%0d]", i), rlevel, tbl[i].lvl);
      chk($sformatf("ae[%0d]", i), ralmost_empty, tbl[i].ae);
      chk($sformatf("lvl rinc[%0d]", i), rinc, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
